// File: rtl/aes_key_expand_seq.sv
// AES key-schedule word generator: loads an NK-word cipher key and streams
// w[0..NW-1] one word per valid/ready handshake, using an external S-box.
module aes_key_expand_seq #(
  parameter int unsigned NK        = 4,
  parameter int unsigned ROT_BYTES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [32*NK-1:0] key_in,
  output logic [31:0]      sbox_in,
  input  logic [31:0]      sbox_out,
  output logic [31:0]      word_out,
  output logic [5:0]       word_idx,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NR      = NK + 6;
  localparam int unsigned NW      = 4 * (NR + 1);
  localparam int unsigned PH_W    = $clog2(NK);
  localparam int unsigned ROT_W   = 8 * ROT_BYTES;
  localparam bit          SUB_MID = (NK == 8);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_key_expand_seq: NK must be 4, 6 or 8");
  end
  if (ROT_BYTES < 1 || ROT_BYTES > 3) begin : g_bad_rot
    $error("aes_key_expand_seq: ROT_BYTES must be 1..3");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_win [NK];
  logic [31:0]       w_win_nxt [NK];
  logic [31:0]       w_key_words [NK];
  logic [7:0]        r_rcon, w_rcon_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt, w_phase_inc;
  logic [31:0]       r_word, w_word_nxt;
  logic [5:0]        r_idx, w_idx_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_accept;
  logic              w_sub_mid;
  logic [31:0]       w_rot;
  logic [31:0]       w_temp;
  logic [31:0]       w_gen;

  assign word_out   = r_word;
  assign word_idx   = r_idx;
  assign word_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;

  assign w_accept    = r_valid & word_ready;
  assign w_phase_inc = (r_phase == PH_W'(NK - 1)) ? '0 : r_phase + PH_W'(1);

  // w[0] sits in the most significant word of key_in
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      w_key_words[k] = key_in[32*(NK-k)-1 -: 32];
    end
  end

  // Next word: window holds w[j-NK+1..j] while w[j] is on the output
  always_comb begin
    w_rot     = (r_win[NK-1] << ROT_W) | (r_win[NK-1] >> (32 - ROT_W));
    w_sub_mid = SUB_MID && (w_phase_inc == PH_W'(NK / 2));
    sbox_in   = w_sub_mid ? r_win[NK-1] : w_rot;
    w_temp    = r_win[NK-1];
    if (w_phase_inc == '0) begin
      w_temp = sbox_out ^ {r_rcon, 24'h0};
    end else if (w_sub_mid) begin
      w_temp = sbox_out;
    end
    w_gen = r_win[0] ^ w_temp;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_rcon_nxt  = r_rcon;
    w_phase_nxt = r_phase;
    w_word_nxt  = r_word;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_win_nxt   = w_key_words;
          w_word_nxt  = w_key_words[0];
          w_idx_nxt   = '0;
          w_phase_nxt = '0;
          w_rcon_nxt  = 8'h01;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_idx_nxt   = r_idx + 6'd1;
          w_phase_nxt = w_phase_inc;
          if (r_phase == PH_W'(NK - 1)) begin
            w_state_nxt = S_EXPAND;
            w_word_nxt  = w_gen;
            for (int k = 0; k < NK - 1; k++) w_win_nxt[k] = r_win[k+1];
            w_win_nxt[NK-1] = w_gen;
          end else begin
            w_word_nxt = r_win[w_phase_inc];
          end
        end
      end
      S_EXPAND: begin
        if (w_accept) begin
          if (r_phase == '0) begin
            w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
          end
          if (r_idx == 6'(NW - 1)) begin
            w_state_nxt = S_DONE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_word_nxt  = w_gen;
            w_idx_nxt   = r_idx + 6'd1;
            w_phase_nxt = w_phase_inc;
            for (int k = 0; k < NK - 1; k++) w_win_nxt[k] = r_win[k+1];
            w_win_nxt[NK-1] = w_gen;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      for (int k = 0; k < NK; k++) r_win[k] <= '0;
      r_rcon  <= 8'h01;
      r_phase <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      for (int k = 0; k < NK; k++) r_win[k] <= w_win_nxt[k];
      r_rcon  <= w_rcon_nxt;
      r_phase <= w_phase_nxt;
      r_word  <= w_word_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: NK=4/6/8 instances checked against a
// straightforward key-schedule model, with random keys and back-pressure.
module tb_aes_key_expand_seq;

  localparam int ROT = 1;
  localparam logic [255:0] KEY128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, ready;
  int           sel;
  logic [255:0] key_bus;
  logic [7:0]   sbox_tab [256];
  logic [31:0]  exp_w [60];
  logic [31:0]  got_w [60];
  int           n_checks = 0;
  int           n_fail   = 0;

  logic [31:0] sbi4, sbo4, wo4, sbi6, sbo6, wo6, sbi8, sbo8, wo8;
  logic [5:0]  ix4, ix6, ix8;
  logic        v4, b4, d4, v6, b6, d6, v8, b8, d8;
  logic        st4, st6, st8;

  assign st4 = start && (sel == 4);
  assign st6 = start && (sel == 6);
  assign st8 = start && (sel == 8);

  assign sbo4 = {sbox_tab[sbi4[31:24]], sbox_tab[sbi4[23:16]], sbox_tab[sbi4[15:8]], sbox_tab[sbi4[7:0]]};
  assign sbo6 = {sbox_tab[sbi6[31:24]], sbox_tab[sbi6[23:16]], sbox_tab[sbi6[15:8]], sbox_tab[sbi6[7:0]]};
  assign sbo8 = {sbox_tab[sbi8[31:24]], sbox_tab[sbi8[23:16]], sbox_tab[sbi8[15:8]], sbox_tab[sbi8[7:0]]};

  aes_key_expand_seq #(.NK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .key_in(key_bus[127:0]),
    .sbox_in(sbi4), .sbox_out(sbo4), .word_out(wo4), .word_idx(ix4),
    .word_valid(v4), .word_ready(ready), .busy(b4), .done(d4)
  );
  aes_key_expand_seq #(.NK(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(st6), .key_in(key_bus[191:0]),
    .sbox_in(sbi6), .sbox_out(sbo6), .word_out(wo6), .word_idx(ix6),
    .word_valid(v6), .word_ready(ready), .busy(b6), .done(d6)
  );
  aes_key_expand_seq #(.NK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .key_in(key_bus[255:0]),
    .sbox_in(sbi8), .sbox_out(sbo8), .word_out(wo8), .word_idx(ix8),
    .word_valid(v8), .word_ready(ready), .busy(b8), .done(d8)
  );

  logic [31:0] c_word;
  logic [5:0]  c_idx;
  logic        c_valid, c_busy, c_done;

  always_comb begin
    c_word = wo8; c_idx = ix8; c_valid = v8; c_busy = b8; c_done = d8;
    if (sel == 4) begin
      c_word = wo4; c_idx = ix4; c_valid = v4; c_busy = b4; c_done = d4;
    end else if (sel == 6) begin
      c_word = wo6; c_idx = ix6; c_valid = v6; c_busy = b6; c_done = d6;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] t, input int n);
    return (t << n) | (t >> (32 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        exp_w[i] = key[32*(nk-i)-1 -: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t  = subw(rotl(t, 8 * ROT)) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % nk == 4) begin
          t = subw(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  // mode 0: plain, 1: stray start pulses in EXPAND and DONE, 2: reset at word 20
  task automatic run_exp(input int nk, input logic [255:0] key, input int rdy_pct, input int mode);
    int          nw      = 4 * (nk + 7);
    int          exp_idx = 0;
    int          cyc     = 1;
    int          done_cyc = -1;
    bit          stalled = 1'b0;
    bit          fin     = 1'b0;
    logic [31:0] last_w  = '0;
    logic [5:0]  last_i  = '0;
    model(nk, key);
    sel = nk;
    @(negedge clk);
    key_bus = key;
    start   = 1'b1;
    ready   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    key_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    while (cyc < 3000) begin
      if (c_done) begin
        check_eq("done_busy", 32'(c_busy), 32'd0);
        check_eq("done_valid", 32'(c_valid), 32'd0);
        check_eq("done_count", exp_idx, nw);
        fin = 1'b1;
        done_cyc = cyc;
      end else begin
        check_eq("busy", 32'(c_busy), 32'd1);
        check_eq("valid", 32'(c_valid), 32'd1);
      end
      if (c_valid) begin
        if (stalled) begin
          check_eq("stall_word", c_word, last_w);
          check_eq("stall_idx", 32'(c_idx), 32'(last_i));
        end
        check_eq("idx", 32'(c_idx), exp_idx);
        if (exp_idx < nw) begin
          check_eq("word", c_word, exp_w[exp_idx]);
          got_w[exp_idx] = c_word;
        end
      end
      if (mode == 2 && c_valid && c_idx == 6'd20) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_word", c_word, 32'h0);
        check_eq("rst_idx", 32'(c_idx), 32'h0);
        check_eq("rst_valid", 32'(c_valid), 32'h0);
        check_eq("rst_busy", 32'(c_busy), 32'h0);
        check_eq("rst_done", 32'(c_done), 32'h0);
        rst_n = 1'b1;
        repeat (2) begin
          @(negedge clk);
          check_eq("rst_idle_done", 32'(c_done), 32'h0);
          check_eq("rst_idle_valid", 32'(c_valid), 32'h0);
        end
        return;
      end
      start   = (mode == 1) && ((c_valid && c_idx == 6'(nk + 3)) || c_done);
      ready   = ($urandom_range(99) < rdy_pct);
      stalled = c_valid && !ready;
      last_w  = c_word;
      last_i  = c_idx;
      if (c_valid && ready) exp_idx++;
      if (fin) break;
      @(negedge clk);
      cyc++;
    end
    if (!fin) check_eq("timeout", 32'd0, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("post_valid", 32'(c_valid), 32'd0);
      check_eq("post_done", 32'(c_done), 32'd0);
      check_eq("post_busy", 32'(c_busy), 32'd0);
    end
    if (rdy_pct >= 100 && fin) check_eq("latency", done_cyc, nw + 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    ready   = 1'b0;
    sel     = 4;
    key_bus = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    check_eq("reset_word", c_word, 32'h0);
    check_eq("reset_idx", 32'(c_idx), 32'h0);
    check_eq("reset_valid", 32'(c_valid), 32'h0);
    check_eq("reset_busy", 32'(c_busy), 32'h0);
    check_eq("reset_done", 32'(c_done), 32'h0);
    rst_n = 1'b1;

    run_exp(4, KEY128, 100, 0);
    check_eq("k128_w0", got_w[0], 32'h2b7e1516);
    check_eq("k128_w4", got_w[4], 32'ha0fafe17);
    check_eq("k128_w43", got_w[43], 32'hb6630ca6);

    run_exp(6, KEY192, 100, 0);
    check_eq("k192_w6", got_w[6], 32'hfe0c91f7);
    check_eq("k192_w51", got_w[51], 32'h01002202);

    run_exp(8, KEY256, 100, 0);
    check_eq("k256_w8", got_w[8], 32'h9ba35411);
    check_eq("k256_w59", got_w[59], 32'h706c631e);

    run_exp(4, KEY128, 55, 0);
    check_eq("bp_w43", got_w[43], 32'hb6630ca6);

    for (int r = 0; r < 2; r++) begin
      run_exp(4, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 70, 0);
      run_exp(6, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 70, 0);
      run_exp(8, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 70, 0);
    end

    run_exp(4, KEY128, 100, 2);
    run_exp(4, KEY128, 100, 0);
    check_eq("restart_w4", got_w[4], 32'ha0fafe17);

    run_exp(4, KEY128, 100, 1);
    run_exp(8, KEY256, 80, 1);
    check_eq("startign_w59", got_w[59], 32'h706c631e);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
